// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS phase synthesiser: default widths, step limits,
// the dither LFSR polynomial/seed and the phase quadrant type.
package dds_pkg;

    localparam int          DDS_ACC_W    = 32;
    localparam int          DDS_ADDR_W   = 10;
    localparam int          DDS_DATA_W   = 10;
    localparam logic [31:0] DDS_STEP_MIN = 32'd1;
    localparam logic [31:0] DDS_STEP_MAX = 32'h8000_0000;
    localparam logic [31:0] DDS_STEP_RST = 32'd10000;
    localparam int          DDS_MID      = 2 ** (DDS_DATA_W - 1);

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quadrant_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/dds_sine_rom.sv
// Quarter-wave sine table, A[i] = round(AMP*sin(pi/2*(i+0.5)/N)) with AMP = 2^AMP_W-1,
// generated at elaboration; one registered read per clock while ce is high.
module dds_sine_rom #(
    parameter int IDX_W = 8,
    parameter int AMP_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [IDX_W-1:0] idx,
    output logic [AMP_W-1:0] amp
);

    localparam int  N   = 2 ** IDX_W;
    localparam int  AMP = 2 ** AMP_W - 1;
    localparam real PI  = 3.14159265358979;

    function automatic logic [N*AMP_W-1:0] gen_table();
        logic [N*AMP_W-1:0] table_bits;
        real                x;
        table_bits = '0;
        for (int i = 0; i < N; i++) begin
            x = real'(AMP) * $sin(PI / 2.0 * (real'(i) + 0.5) / real'(N));
            table_bits[i*AMP_W +: AMP_W] = AMP_W'($rtoi(x + 0.5));
        end
        return table_bits;
    endfunction

    localparam logic [N*AMP_W-1:0] TABLE = gen_table();

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    // NOTE: only the read register is reset; the table is a constant and needs no reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            amp <= '0;
        end else if (ce) begin
            amp <= TABLE[idx*AMP_W +: AMP_W];
        end
    end

endmodule

// File: rtl/dds_phase_synth.sv
// Phase accumulator feeding a 3-stage quarter-wave lookup that produces offset-binary sine
// samples. Build macro PHASE_DITHER_EN adds LFSR dither to the lookup copy of the phase.
module dds_phase_synth
    import dds_pkg::*;
#(
    parameter int               ACC_W    = DDS_ACC_W,
    parameter int               ADDR_W   = DDS_ADDR_W,
    parameter int               DATA_W   = DDS_DATA_W,
    parameter logic [ACC_W-1:0] STEP_MIN = ACC_W'(DDS_STEP_MIN),
    parameter logic [ACC_W-1:0] STEP_MAX = ACC_W'(DDS_STEP_MAX),
    parameter logic [ACC_W-1:0] STEP_RST = ACC_W'(DDS_STEP_RST)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ACC_W-1:0]  step,
    input  logic              step_load,
    input  logic              phase_clr,
    output logic [ACC_W-1:0]  phase_out,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              wrap_pulse
);

    localparam int                IDX_W  = ADDR_W - 2;
    localparam int                AMP_W  = DATA_W - 1;
    localparam logic [DATA_W-1:0] MID    = DATA_W'(2 ** (DATA_W - 1));
    localparam logic [DATA_W-1:0] MID_LO = DATA_W'(2 ** (DATA_W - 1) - 1);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  step_reg;
    logic [ACC_W-1:0]  step_clamped;
    logic              acc_wrap;
    logic              acc_valid;
    logic              wrap_next;

    logic [ADDR_W-1:0] lookup_bits;
    logic [IDX_W-1:0]  idx_raw;
    quadrant_t         quad_now;

    quadrant_t         q1;
    logic [IDX_W-1:0]  idx1;
    logic              wrap1;
    logic              valid1;

    quadrant_t         q2;
    logic [AMP_W-1:0]  amp2;
    logic              wrap2;
    logic              valid2;

    // NOTE: default first so every path assigns step_clamped and no latch is inferred.
    always_comb begin
        step_clamped = step;
        if (step < STEP_MIN) begin
            step_clamped = STEP_MIN;
        end else if (step > STEP_MAX) begin
            step_clamped = STEP_MAX;
        end
    end

    assign {wrap_next, acc_next} = {1'b0, acc} + {1'b0, step_reg};

    // The accumulator keeps running across step loads, so retuning is phase-continuous.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            acc_wrap  <= 1'b0;
            acc_valid <= 1'b0;
            step_reg  <= STEP_RST;
        end else begin
            if (step_load) begin
                step_reg <= step_clamped;
            end
            if (phase_clr) begin
                acc      <= '0;
                acc_wrap <= 1'b0;
            end else if (enable) begin
                acc      <= acc_next;
                acc_wrap <= wrap_next;
            end
            if (enable || phase_clr) begin
                acc_valid <= 1'b1;
            end
        end
    end

    assign phase_out = acc;

`ifdef PHASE_DITHER_EN
    localparam int DITHER_W = (ACC_W - ADDR_W > LFSR_W) ? LFSR_W : (ACC_W - ADDR_W);

    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else if (enable) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Dither only perturbs the lookup copy; acc and phase_out stay exact.
    assign lookup_bits = ADDR_W'((acc + ACC_W'(lfsr[LFSR_W-1 -: DITHER_W])) >> (ACC_W - ADDR_W));
`else
    assign lookup_bits = acc[ACC_W-1 -: ADDR_W];
`endif

    assign quad_now = quadrant_t'(lookup_bits[ADDR_W-1 -: 2]);
    assign idx_raw  = lookup_bits[IDX_W-1:0];

    // S1: quadrant split; odd quadrants walk the quarter table backwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q1     <= QUAD_0;
            idx1   <= '0;
            wrap1  <= 1'b0;
            valid1 <= 1'b0;
        end else if (enable) begin
            q1     <= quad_now;
            idx1   <= lookup_bits[ADDR_W-2] ? ~idx_raw : idx_raw;
            wrap1  <= acc_wrap;
            valid1 <= acc_valid;
        end
    end

    // S2: table read, with quadrant and wrap travelling alongside.
    dds_sine_rom #(
        .IDX_W (IDX_W),
        .AMP_W (AMP_W)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .ce    (enable),
        .idx   (idx1),
        .amp   (amp2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q2     <= QUAD_0;
            wrap2  <= 1'b0;
            valid2 <= 1'b0;
        end else if (enable) begin
            q2     <= q1;
            wrap2  <= wrap1;
            valid2 <= valid1;
        end
    end

    // S3: fold into offset binary; sample only moves when a valid phase arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample       <= MID;
            sample_valid <= 1'b0;
            wrap_pulse   <= 1'b0;
        end else begin
            sample_valid <= enable & valid2;
            wrap_pulse   <= enable & valid2 & wrap2;
            if (enable && valid2) begin
                if (q2 inside {QUAD_2, QUAD_3}) begin
                    sample <= MID_LO - {1'b0, amp2};
                end else begin
                    sample <= MID + {1'b0, amp2};
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_phase_synth.sv
// Self-checking bench for dds_phase_synth: directed scenarios plus randomized traffic,
// compared against a reference model built from phase arithmetic and a sine formula.
module tb_dds_phase_synth;

    localparam real PI = 3.14159265358979;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] step;
    logic        step_load;
    logic        phase_clr;
    logic [31:0] phase_out;
    logic [9:0]  sample;
    logic        sample_valid;
    logic        wrap_pulse;

    int tests_run = 0;
    int failed    = 0;

    always #5 clk = ~clk;

    dds_phase_synth dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .step         (step),
        .step_load    (step_load),
        .phase_clr    (phase_clr),
        .phase_out    (phase_out),
        .sample       (sample),
        .sample_valid (sample_valid),
        .wrap_pulse   (wrap_pulse)
    );

    // Reference model: history of accumulator states, the sample appears three enabled edges later.
    typedef struct {
        logic [31:0] phase;
        logic        wrap;
        logic        valid;
    } entry_t;

    entry_t      hist[$];
    logic [31:0] m_acc;
    logic [31:0] m_step;
    logic [9:0]  m_sample;
    logic        m_valid;
    logic        m_wrap;

    function automatic logic [9:0] sine_of(input logic [31:0] ph);
        int quad;
        int idx;
        int amp;
        quad = int'(ph[31:30]);
        idx  = int'(ph[29:22]);
        if (quad % 2 == 1) idx = 255 - idx;
        amp = $rtoi(511.0 * $sin(PI / 2.0 * (real'(idx) + 0.5) / 256.0) + 0.5);
        if (quad >= 2) return 10'(511 - amp);
        return 10'(512 + amp);
    endfunction

    function automatic logic [31:0] clamp_step(input logic [31:0] s);
        if (s < 32'd1) return 32'd1;
        if (s > 32'h8000_0000) return 32'h8000_0000;
        return s;
    endfunction

    task automatic model_reset();
        entry_t e;
        m_acc    = 32'd0;
        m_step   = 32'd10000;
        m_sample = 10'd512;
        m_valid  = 1'b0;
        m_wrap   = 1'b0;
        hist.delete();
        e.phase = 32'd0;
        e.wrap  = 1'b0;
        e.valid = 1'b0;
        hist.push_back(e);
    endtask

    task automatic tick(input logic en, input logic clr, input logic ld, input logic [31:0] stp);
        entry_t      e;
        logic [32:0] sum;
        logic [31:0] nstep;
        enable    = en;
        phase_clr = clr;
        step_load = ld;
        step      = stp;
        @(posedge clk);
        nstep = ld ? clamp_step(stp) : m_step;
        m_valid = 1'b0;
        m_wrap  = 1'b0;
        if (en) begin
            if (clr) begin
                e.phase = 32'd0;
                e.wrap  = 1'b0;
            end else begin
                sum     = {1'b0, m_acc} + {1'b0, m_step};
                e.phase = sum[31:0];
                e.wrap  = sum[32];
            end
            e.valid = 1'b1;
            hist.push_back(e);
            if (hist.size() > 4) void'(hist.pop_front());
            if (hist.size() == 4 && hist[0].valid) begin
                m_sample = sine_of(hist[0].phase);
                m_valid  = 1'b1;
                m_wrap   = hist[0].wrap;
            end
            m_acc = e.phase;
        end
        m_step = nstep;
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        enable    = 1'b0;
        step      = 32'd0;
        step_load = 1'b0;
        phase_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (phase_out !== 32'd0) begin failed++; $display("FAIL reset_phase: got %h want 00000000", phase_out); end
        tests_run++; if (sample !== 10'd512) begin failed++; $display("FAIL reset_sample: got %0d want 512", sample); end
        tests_run++; if (sample_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
        tests_run++; if (wrap_pulse !== 1'b0) begin failed++; $display("FAIL reset_wrap: got %b want 0", wrap_pulse); end
        reset = 1'b1;
    endtask

    task automatic test_startup();
        for (int k = 1; k <= 6; k++) begin
            tick(1'b1, 1'b0, 1'b0, 32'd0);
            tests_run++;
            if (phase_out !== 32'(10000 * k)) begin
                failed++; $display("FAIL startup_phase[%0d]: got %0d want %0d", k, phase_out, 10000 * k);
            end
            tests_run++;
            if (sample_valid !== (k >= 4)) begin
                failed++; $display("FAIL startup_valid[%0d]: got %b want %b", k, sample_valid, (k >= 4));
            end
            tests_run++;
            if (sample !== m_sample) begin
                failed++; $display("FAIL startup_sample[%0d]: got %0d want %0d", k, sample, m_sample);
            end
        end
    endtask

    task automatic test_quadrants();
        logic [9:0] pattern [4];
        pattern[0] = 10'd514; pattern[1] = 10'd1023; pattern[2] = 10'd509; pattern[3] = 10'd0;
        tick(1'b1, 1'b1, 1'b1, 32'h4000_0000);
        for (int j = 1; j <= 14; j++) begin
            tick(1'b1, 1'b0, 1'b0, 32'd0);
            if (j >= 3) begin
                tests_run++;
                if (sample !== pattern[(j - 3) % 4]) begin
                    failed++; $display("FAIL quad_sample[%0d]: got %0d want %0d", j, sample, pattern[(j - 3) % 4]);
                end
                tests_run++;
                if (wrap_pulse !== ((j - 3) % 4 == 0 && j >= 7)) begin
                    failed++; $display("FAIL quad_wrap[%0d]: got %b want %b", j, wrap_pulse, ((j - 3) % 4 == 0 && j >= 7));
                end
            end else begin
                tests_run++;
                if (sample !== m_sample) begin
                    failed++; $display("FAIL quad_lead_sample[%0d]: got %0d want %0d", j, sample, m_sample);
                end
            end
        end
    endtask

    task automatic test_clamp();
        logic [31:0] p0;
        tick(1'b1, 1'b0, 1'b1, 32'd0);
        p0 = phase_out;
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        tests_run++;
        if (phase_out !== p0 + 32'd1) begin
            failed++; $display("FAIL clamp_floor: got %h want %h", phase_out, p0 + 32'd1);
        end
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        for (int j = 1; j <= 10; j++) begin
            tick(1'b1, 1'b0, 1'b0, 32'd0);
            tests_run++;
            if (phase_out !== ((j % 2 == 1) ? 32'h8000_0000 : 32'd0)) begin
                failed++; $display("FAIL clamp_ceiling_phase[%0d]: got %h", j, phase_out);
            end
            if (j >= 3) begin
                tests_run++;
                if (sample !== (((j - 3) % 2 == 0) ? 10'd514 : 10'd509)) begin
                    failed++; $display("FAIL clamp_sample[%0d]: got %0d want %0d", j, sample, (((j - 3) % 2 == 0) ? 514 : 509));
                end
                tests_run++;
                if (wrap_pulse !== ((j - 3) % 2 == 0 && j >= 5)) begin
                    failed++; $display("FAIL clamp_wrap[%0d]: got %b want %b", j, wrap_pulse, ((j - 3) % 2 == 0 && j >= 5));
                end
            end
        end
    endtask

    task automatic test_continuity();
        tick(1'b1, 1'b1, 1'b1, 32'h2000_0000);
        tick(1'b1, 1'b0, 1'b1, 32'h4000_0000);
        tests_run++;
        if (phase_out !== 32'h2000_0000) begin failed++; $display("FAIL cont_phase0: got %h want 20000000", phase_out); end
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        tests_run++;
        if (phase_out !== 32'h6000_0000) begin failed++; $display("FAIL cont_phase1: got %h want 60000000", phase_out); end
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        tests_run++;
        if (phase_out !== 32'hA000_0000) begin failed++; $display("FAIL cont_phase2: got %h want a0000000", phase_out); end
        for (int j = 0; j < 5; j++) begin
            tick(1'b1, 1'b0, 1'b0, 32'd0);
            tests_run++;
            if (sample !== m_sample || wrap_pulse !== m_wrap) begin
                failed++; $display("FAIL cont_sample[%0d]: got %0d/%b want %0d/%b", j, sample, wrap_pulse, m_sample, m_wrap);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] hold_phase;
        logic [9:0]  hold_sample;
        tick(1'b1, 1'b1, 1'b1, 32'h0123_4567);
        repeat (4) tick(1'b1, 1'b0, 1'b0, 32'd0);
        hold_phase  = phase_out;
        hold_sample = sample;
        for (int j = 0; j < 5; j++) begin
            tick(1'b0, 1'b0, 1'b0, 32'd0);
            tests_run++;
            if (phase_out !== hold_phase || sample !== hold_sample || sample_valid !== 1'b0) begin
                failed++; $display("FAIL stall_hold[%0d]: got %h/%0d/%b want %h/%0d/0", j, phase_out, sample, sample_valid, hold_phase, hold_sample);
            end
        end
        for (int j = 0; j < 6; j++) begin
            tick(1'b1, 1'b0, 1'b0, 32'd0);
            tests_run++;
            if (phase_out !== m_acc || sample !== m_sample || sample_valid !== m_valid) begin
                failed++; $display("FAIL stall_resume[%0d]: got %h/%0d/%b want %h/%0d/%b", j, phase_out, sample, sample_valid, m_acc, m_sample, m_valid);
            end
        end
    endtask

    task automatic test_random();
        logic        en;
        logic        clr;
        logic        ld;
        logic [31:0] stp;
        for (int n = 0; n < 300; n++) begin
            en  = ($urandom_range(0, 3) != 0);
            clr = en && ($urandom_range(0, 19) == 0);
            ld  = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       stp = 32'd0;
                1:       stp = 32'hFFFF_FFFF;
                2:       stp = 32'($urandom);
                default: stp = 32'($urandom_range(1, 1 << 24));
            endcase
            tick(en, clr, ld, stp);
            tests_run++;
            if (phase_out !== m_acc || sample !== m_sample || sample_valid !== m_valid || wrap_pulse !== m_wrap) begin
                failed++;
                $display("FAIL random[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b", n, phase_out, sample, sample_valid, wrap_pulse,
                         m_acc, m_sample, m_valid, m_wrap);
            end
        end
    endtask

    task automatic test_reset_mid_wrap();
        tick(1'b1, 1'b1, 1'b1, 32'h8000_0000);
        for (int i = 0; i < 10 && wrap_pulse !== 1'b1; i++) tick(1'b1, 1'b0, 1'b0, 32'd0);
        tests_run++;
        if (wrap_pulse !== 1'b1) begin failed++; $display("FAIL wrap_wait: got %b want 1 within 10 cycles", wrap_pulse); end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (phase_out !== 32'd0 || sample !== 10'd512 || sample_valid !== 1'b0 || wrap_pulse !== 1'b0) begin
            failed++; $display("FAIL async_reset: got %h/%0d/%b/%b want 00000000/512/0/0", phase_out, sample, sample_valid, wrap_pulse);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (phase_out !== 32'd0 || sample !== 10'd512) begin
            failed++; $display("FAIL reset_held: got %h/%0d want 00000000/512", phase_out, sample);
        end
        reset = 1'b1;
        model_reset();
        test_startup();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_startup();
        test_quadrants();
        test_clamp();
        test_continuity();
        test_stall();
        test_random();
        test_reset_mid_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
